dram_init_seq: RTL and testbench



---
 rtl/dram_init_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_dram_init_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_init_seq.sv
// dram_init_seq -- DDR3 power-up and initialisation sequencer.
//
// After a one-cycle start request it walks the JEDEC power-up order for
// NRANK ranks: RESET# low, RESET# high with CKE low, CKE high (tXPR),
// MR2/MR3/MR1/MR0 per rank, then optionally one ZQCL per rank. When the
// sequence ends it hands the command pins to the controller as a
// registered pass-through.
//
// Optional feature macro: DRAM_INIT_ZQCL_EN
//   defined   -> one ZQCL per rank after mode-register setup, each followed
//                by T_ZQINIT-1 deselect cycles.
//   undefined -> the ZQ phase is skipped, MRS goes straight to DONE.
//
// Every output is a flop whose next value is decoded from the current
// sequencer state, so outputs trail the state register by one dclk.

module dram_init_seq #(
   parameter int          NRANK    = 2,
   parameter int          ADDR_W   = 16,
   parameter int          BA_W     = 3,
   parameter int          T_RESET  = 25000,
   parameter int          T_CKE    = 62500,
   parameter int          T_XPR    = 48,
   parameter int          T_MRD    = 4,
   parameter int          T_MOD    = 12,
   parameter int          T_ZQINIT = 512,
   parameter logic [15:0] MR0      = 16'h0520,
   parameter logic [15:0] MR1      = 16'h0044,
   parameter logic [15:0] MR2      = 16'h0008,
   parameter logic [15:0] MR3      = 16'h0000
) (
   input  logic              dclk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic [NRANK-1:0]  ctl_cke,
   input  logic [NRANK-1:0]  ctl_s_n,
   input  logic [NRANK-1:0]  ctl_odt,
   input  logic              ctl_ras_n,
   input  logic              ctl_cas_n,
   input  logic              ctl_we_n,
   input  logic [BA_W-1:0]   ctl_ba,
   input  logic [ADDR_W-1:0] ctl_addr,
   output logic              dram_reset_n,
   output logic [NRANK-1:0]  cke,
   output logic [NRANK-1:0]  s_n,
   output logic [NRANK-1:0]  odt,
   output logic              ras_n,
   output logic              cas_n,
   output logic              we_n,
   output logic [BA_W-1:0]   ba,
   output logic [ADDR_W-1:0] addr
);

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared down-counter covers every wait, so it is sized for the
   // longest timing parameter.
   localparam int MAX_T  = max_of(max_of(max_of(T_RESET, T_CKE), max_of(T_XPR, T_MRD)),
                                  max_of(T_MOD, T_ZQINIT));
   localparam int CNT_W  = $clog2(MAX_T) + 1;
   localparam int RANK_W = $clog2(NRANK) + 1;

   // Counter load values: a phase of L cycles loads L-1 and ends on zero.
   localparam logic [CNT_W-1:0]  LD_RESET  = CNT_W'(T_RESET - 1);
   localparam logic [CNT_W-1:0]  LD_CKE    = CNT_W'(T_CKE - 1);
   localparam logic [CNT_W-1:0]  LD_XPR    = CNT_W'(T_XPR - 1);
   localparam logic [CNT_W-1:0]  LD_MRD    = CNT_W'(T_MRD - 1);
   localparam logic [CNT_W-1:0]  LD_MOD    = CNT_W'(T_MOD - 1);
   localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NRANK - 1);
`ifdef DRAM_INIT_ZQCL_EN
   localparam logic [CNT_W-1:0]  LD_ZQ     = CNT_W'(T_ZQINIT - 1);
   // ZQCL: A10 high selects the long calibration.
   localparam logic [ADDR_W-1:0] ZQ_ADDR   = ADDR_W'(1024);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LOW,
      S_CKE_WAIT,
      S_XPR,
      S_MRS,
      S_ZQ,
      S_DONE
   } state_t;

   // Sequencer state.
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic [1:0]        step_q, step_d;    // 0:MR2 1:MR3 2:MR1 3:MR0
   logic              first_q, first_d;  // first cycle of an MRS/ZQ slot = command cycle

   // Registered pin values.
   logic              dram_reset_n_q, dram_reset_n_d;
   logic [NRANK-1:0]  cke_q, cke_d;
   logic [NRANK-1:0]  s_n_q, s_n_d;
   logic [NRANK-1:0]  odt_q, odt_d;
   logic              ras_n_q, ras_n_d;
   logic              cas_n_q, cas_n_d;
   logic              we_n_q, we_n_d;
   logic [BA_W-1:0]   ba_q, ba_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              cnt_zero;
   logic [CNT_W-1:0]  cnt_dec;
   logic [NRANK-1:0]  rank_sel_n;
   logic [BA_W-1:0]   mr_ba;
   logic [ADDR_W-1:0] mr_val;

   assign cnt_zero   = (cnt_q == '0);
   assign cnt_dec    = cnt_q - CNT_W'(1);
   assign rank_sel_n = ~(NRANK'(1) << rank_q);

   // Mode-register select for the current step: JEDEC order MR2, MR3, MR1, MR0.
   always_comb begin
      mr_ba  = '0;
      mr_val = '0;
      case (step_q)
         2'd0:    begin mr_ba = BA_W'(2); mr_val = ADDR_W'(MR2); end
         2'd1:    begin mr_ba = BA_W'(3); mr_val = ADDR_W'(MR3); end
         2'd2:    begin mr_ba = BA_W'(1); mr_val = ADDR_W'(MR1); end
         default: begin mr_ba = BA_W'(0); mr_val = ADDR_W'(MR0); end
      endcase
   end

   // Next-state logic: phase sequencing, slot counting and rank stepping.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rank_d  = rank_q;
      step_d  = step_q;
      first_d = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RST_LOW;
               cnt_d   = LD_RESET;
               rank_d  = '0;
               step_d  = '0;
            end
         end

         S_RST_LOW: begin
            if (cnt_zero) begin
               state_d = S_CKE_WAIT;
               cnt_d   = LD_CKE;
            end else begin
               cnt_d = cnt_dec;
            end
         end

         S_CKE_WAIT: begin
            if (cnt_zero) begin
               state_d = S_XPR;
               cnt_d   = LD_XPR;
            end else begin
               cnt_d = cnt_dec;
            end
         end

         S_XPR: begin
            if (cnt_zero) begin
               state_d = S_MRS;
               cnt_d   = LD_MRD;
               rank_d  = '0;
               step_d  = '0;
               first_d = 1'b1;
            end else begin
               cnt_d = cnt_dec;
            end
         end

         S_MRS: begin
            if (!cnt_zero) begin
               cnt_d = cnt_dec;
            end else if (step_q != 2'd3) begin
               // MR0 is the last step of a rank and is followed by tMOD.
               step_d  = step_q + 2'd1;
               cnt_d   = (step_q == 2'd2) ? LD_MOD : LD_MRD;
               first_d = 1'b1;
            end else if (rank_q != LAST_RANK) begin
               rank_d  = rank_q + RANK_W'(1);
               step_d  = '0;
               cnt_d   = LD_MRD;
               first_d = 1'b1;
            end else begin
`ifdef DRAM_INIT_ZQCL_EN
               state_d = S_ZQ;
               rank_d  = '0;
               cnt_d   = LD_ZQ;
               first_d = 1'b1;
`else
               state_d = S_DONE;
`endif
            end
         end

`ifdef DRAM_INIT_ZQCL_EN
         S_ZQ: begin
            if (!cnt_zero) begin
               cnt_d = cnt_dec;
            end else if (rank_q != LAST_RANK) begin
               rank_d  = rank_q + RANK_W'(1);
               cnt_d   = LD_ZQ;
               first_d = 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // Pin decode: deselect by default, command cycles at slot starts, pass-through in DONE.
   always_comb begin
      dram_reset_n_d = 1'b1;
      cke_d          = '0;
      s_n_d          = '1;
      odt_d          = '0;
      ras_n_d        = 1'b1;
      cas_n_d        = 1'b1;
      we_n_d         = 1'b1;
      ba_d           = '0;
      addr_d         = '0;
      busy_d         = 1'b1;
      done_d         = 1'b0;

      case (state_q)
         S_RST_LOW:  dram_reset_n_d = 1'b0;
         S_CKE_WAIT: ;
         S_XPR:      cke_d = '1;

         S_MRS: begin
            cke_d = '1;
            if (first_q) begin
               s_n_d   = rank_sel_n;
               ras_n_d = 1'b0;
               cas_n_d = 1'b0;
               we_n_d  = 1'b0;
               ba_d    = mr_ba;
               addr_d  = mr_val;
            end
         end

`ifdef DRAM_INIT_ZQCL_EN
         S_ZQ: begin
            cke_d = '1;
            if (first_q) begin
               s_n_d  = rank_sel_n;
               we_n_d = 1'b0;
               addr_d = ZQ_ADDR;
            end
         end
`endif

         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cke_d   = ctl_cke;
            s_n_d   = ctl_s_n;
            odt_d   = ctl_odt;
            ras_n_d = ctl_ras_n;
            cas_n_d = ctl_cas_n;
            we_n_d  = ctl_we_n;
            ba_d    = ctl_ba;
            addr_d  = ctl_addr;
         end

         // IDLE (and any unused encoding): hold the reset values.
         default: begin
            dram_reset_n_d = 1'b0;
            busy_d         = 1'b0;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge dclk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rank_q  <= '0;
         step_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rank_q  <= rank_d;
         step_q  <= step_d;
         first_q <= first_d;
      end
   end

   // Output registers; reset puts the DRAM pins in their safe power-up state at once.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         dram_reset_n_q <= 1'b0;
         cke_q          <= '0;
         s_n_q          <= '1;
         odt_q          <= '0;
         ras_n_q        <= 1'b1;
         cas_n_q        <= 1'b1;
         we_n_q         <= 1'b1;
         ba_q           <= '0;
         addr_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         dram_reset_n_q <= dram_reset_n_d;
         cke_q          <= cke_d;
         s_n_q          <= s_n_d;
         odt_q          <= odt_d;
         ras_n_q        <= ras_n_d;
         cas_n_q        <= cas_n_d;
         we_n_q         <= we_n_d;
         ba_q           <= ba_d;
         addr_q         <= addr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign dram_reset_n = dram_reset_n_q;
   assign cke          = cke_q;
   assign s_n          = s_n_q;
   assign odt          = odt_q;
   assign ras_n        = ras_n_q;
   assign cas_n        = cas_n_q;
   assign we_n         = we_n_q;
   assign ba           = ba_q;
   assign addr         = addr_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_dram_init_seq.sv
// tb_dram_init_seq -- self-checking bench for dram_init_seq.
// Expected pin values come from a cycle-offset model of the power-up order
// (phase boundaries and command slots computed arithmetically from the
// timing parameters). Controller inputs are randomised every cycle.

module tb_dram_init_seq;

   localparam int NRANK    = 2;
   localparam int ADDR_W   = 16;
   localparam int BA_W     = 3;
   localparam int T_RESET  = 10;
   localparam int T_CKE    = 20;
   localparam int T_XPR    = 5;
   localparam int T_MRD    = 4;
   localparam int T_MOD    = 12;
   localparam int T_ZQINIT = 32;
   localparam logic [15:0] MR0 = 16'h0520;
   localparam logic [15:0] MR1 = 16'h0044;
   localparam logic [15:0] MR2 = 16'h0008;
   localparam logic [15:0] MR3 = 16'h0000;

   localparam int BLK = 3 * T_MRD + T_MOD;   // one rank's MRS block
`ifdef DRAM_INIT_ZQCL_EN
   localparam int ZQ_TOT = NRANK * T_ZQINIT;
   localparam int ZQ_N   = NRANK;
   localparam int DONE_C = 148;
`else
   localparam int ZQ_TOT = 0;
   localparam int ZQ_N   = 0;
   localparam int DONE_C = 84;
`endif
   localparam int SEQ_LEN = T_RESET + T_CKE + T_XPR + NRANK * BLK + ZQ_TOT;
   localparam int MAXC    = 4096;

   typedef struct packed {
      logic [NRANK-1:0]  cke;
      logic [NRANK-1:0]  s_n;
      logic [NRANK-1:0]  odt;
      logic              ras_n;
      logic              cas_n;
      logic              we_n;
      logic [BA_W-1:0]   ba;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

   typedef struct packed {
      logic rst_n;
      logic busy;
      logic done;
      cmd_t cmd;
   } obs_t;

   logic              dclk = 1'b0;
   logic              reset_n;
   logic              start;
   cmd_t              ctl_v;
   logic              busy, done, dram_reset_n;
   logic [NRANK-1:0]  cke, s_n, odt;
   logic              ras_n, cas_n, we_n;
   logic [BA_W-1:0]   ba;
   logic [ADDR_W-1:0] addr;
   obs_t              obs;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc;                  // posedges since reset release
   int   run_start;            // edge at which the current run was accepted, -1 if none
   logic prev_done;            // state before that run was DONE
   cmd_t ctl_hist [0:MAXC-1];  // controller inputs sampled at each edge

   always #5 dclk = ~dclk;

   dram_init_seq #(
      .NRANK(NRANK), .ADDR_W(ADDR_W), .BA_W(BA_W),
      .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR),
      .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
      .MR0(MR0), .MR1(MR1), .MR2(MR2), .MR3(MR3)
   ) dut (
      .dclk(dclk), .reset_n(reset_n), .start(start),
      .busy(busy), .done(done),
      .ctl_cke(ctl_v.cke), .ctl_s_n(ctl_v.s_n), .ctl_odt(ctl_v.odt),
      .ctl_ras_n(ctl_v.ras_n), .ctl_cas_n(ctl_v.cas_n), .ctl_we_n(ctl_v.we_n),
      .ctl_ba(ctl_v.ba), .ctl_addr(ctl_v.addr),
      .dram_reset_n(dram_reset_n),
      .cke(cke), .s_n(s_n), .odt(odt),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .ba(ba), .addr(addr)
   );

   assign obs = {dram_reset_n, busy, done, cke, s_n, odt, ras_n, cas_n, we_n, ba, addr};

   // ---------------- reference model ----------------
   function automatic cmd_t deselect(input logic [NRANK-1:0] cke_v);
      cmd_t d;
      d.cke = cke_v; d.s_n = '1; d.odt = '0;
      d.ras_n = 1'b1; d.cas_n = 1'b1; d.we_n = 1'b1;
      d.ba = '0; d.addr = '0;
      return d;
   endfunction

   function automatic obs_t idle_obs();
      obs_t o;
      o.rst_n = 1'b0; o.busy = 1'b0; o.done = 1'b0;
      o.cmd = deselect('0);
      return o;
   endfunction

   function automatic obs_t pass_obs(input int k);
      obs_t o;
      o.rst_n = 1'b1; o.busy = 1'b0; o.done = 1'b1;
      o.cmd = (k < MAXC) ? ctl_hist[k] : cmd_t'('0);
      return o;
   endfunction

   // Expected pins after edge k.
   function automatic obs_t exp_at(input int k);
      obs_t o;
      int c, m, z, r, off;
      o = idle_obs();
      if (run_start < 0 || k < run_start) return o;
      c = k - run_start;
      if (c == 0) return prev_done ? pass_obs(k) : o;
      if (c > SEQ_LEN) return pass_obs(k);
      o.busy  = 1'b1;
      o.rst_n = (c > T_RESET);
      o.cmd   = deselect((c > T_RESET + T_CKE) ? '1 : '0);
      m = c - (1 + T_RESET + T_CKE + T_XPR);
      if (m >= 0 && m < NRANK * BLK) begin
         r   = m / BLK;
         off = m % BLK;
         if (off % T_MRD == 0 && off <= 3 * T_MRD) begin
            o.cmd.s_n   = ~(NRANK'(1) << r);
            o.cmd.ras_n = 1'b0; o.cmd.cas_n = 1'b0; o.cmd.we_n = 1'b0;
            case (off / T_MRD)
               0:       begin o.cmd.ba = 3'd2; o.cmd.addr = MR2; end
               1:       begin o.cmd.ba = 3'd3; o.cmd.addr = MR3; end
               2:       begin o.cmd.ba = 3'd1; o.cmd.addr = MR1; end
               default: begin o.cmd.ba = 3'd0; o.cmd.addr = MR0; end
            endcase
         end
      end else if (m >= NRANK * BLK) begin
         z = m - NRANK * BLK;
         r = z / T_ZQINIT;
         if (z % T_ZQINIT == 0) begin
            o.cmd.s_n  = ~(NRANK'(1) << r);
            o.cmd.we_n = 1'b0;
            o.cmd.addr = 16'h0400;
         end
      end
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic check_cycle();
      obs_t e;
      e = exp_at(cyc);
      n_tests++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL cyc%0d observed=%h expected=%h", cyc, obs, e);
      end
   endtask

   task automatic drive_v(input cmd_t v, input logic st);
      obs_t ph;
      ctl_v = v;
      start = st;
      if (cyc + 1 < MAXC) ctl_hist[cyc + 1] = v;
      // The request is honoured only if the sequencer is idle or done.
      if (st && reset_n) begin
         ph = exp_at(cyc + 1);
         if (!ph.busy) begin
            prev_done = ph.done;
            run_start = cyc + 1;
         end
      end
   endtask

   task automatic drive(input logic st);
      logic [31:0] rnd;
      cmd_t v;
      rnd = $urandom;
      v = rnd[$bits(cmd_t)-1:0];
      drive_v(v, st);
   endtask

   task automatic tick();
      @(posedge dclk);
      cyc++;
      @(negedge dclk);
   endtask

   task automatic step(input logic st);
      check_cycle();
      drive(st);
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int   rs, first_done, mrs_seen, zq_seen, low_cnt, c_next;
      logic st;
      logic [31:0] rnd;
      cmd_t v;

      cyc = 0; run_start = -1; prev_done = 1'b0;
      reset_n = 1'b1; start = 1'b0; ctl_v = '0;
      #1 reset_n = 1'b0;
      #1;
      n_tests++;
      assert (obs === idle_obs()) else begin
         n_fail++;
         $error("FAIL reset_hold observed=%h expected=%h", obs, idle_obs());
      end
      @(negedge dclk);
      reset_n = 1'b1;

      // No start: pins stay at reset values.
      repeat (100) step(1'b0);

      // Full sequence, with start pulses while busy that must be ignored.
      step(1'b1);
      rs = run_start;
      first_done = -1; mrs_seen = 0; zq_seen = 0;
      for (int i = 0; i < SEQ_LEN + 20; i++) begin
         c_next = cyc + 1 - rs;
         st = (c_next == 5 || c_next == 40 || $urandom_range(0, 5) == 0) && (c_next <= SEQ_LEN);
         if (cyc > rs && cyc - rs <= SEQ_LEN) begin
            if (!ras_n && !cas_n && !we_n) mrs_seen++;
            if (ras_n && cas_n && !we_n && s_n !== '1) zq_seen++;
         end
         if (first_done < 0 && done === 1'b1 && cyc > rs) first_done = cyc;
         step(st);
      end
      n_tests++;
      assert (first_done - rs === DONE_C) else begin
         n_fail++;
         $error("FAIL done_cycle observed=%0d expected=%0d", first_done - rs, DONE_C);
      end
      n_tests++;
      assert (mrs_seen === 4 * NRANK) else begin
         n_fail++;
         $error("FAIL mrs_count observed=%0d expected=%0d", mrs_seen, 4 * NRANK);
      end
      n_tests++;
      assert (zq_seen === ZQ_N) else begin
         n_fail++;
         $error("FAIL zqcl_count observed=%0d expected=%0d", zq_seen, ZQ_N);
      end

      // Pass-through: one-cycle latency from ctl_* to pins.
      check_cycle();
      rnd = $urandom;
      v = rnd[$bits(cmd_t)-1:0];
      v.addr = 16'hA5A5;
      v.s_n  = 2'b01;
      drive_v(v, 1'b0);
      tick();
      n_tests++;
      assert (addr === 16'hA5A5 && s_n === 2'b01) else begin
         n_fail++;
         $error("FAIL pass_through observed=%h/%b expected=a5a5/01", addr, s_n);
      end
      repeat (3) step(1'b0);

      // Restart from DONE, then abort with reset in the MRS phase.
      step(1'b1);
      rs = run_start;
      low_cnt = 0;
      while (cyc - rs < 50) begin
         if (cyc == rs + 1) begin
            n_tests++;
            assert (done === 1'b0) else begin
               n_fail++;
               $error("FAIL restart_done_low observed=%b expected=0", done);
            end
         end
         if (cyc > rs && dram_reset_n === 1'b0) low_cnt++;
         step(1'b0);
      end
      n_tests++;
      assert (low_cnt === 10) else begin
         n_fail++;
         $error("FAIL restart_reset_low observed=%0d expected=10", low_cnt);
      end

      check_cycle();
      reset_n   = 1'b0;
      run_start = -1;
      prev_done = 1'b0;
      #1;
      n_tests++;
      assert (obs === idle_obs()) else begin
         n_fail++;
         $error("FAIL async_reset observed=%h expected=%h", obs, idle_obs());
      end
      step(1'b0);
      step(1'b0);
      reset_n = 1'b1;
      repeat (5) step(1'b0);

      // Full rerun after the abort.
      step(1'b1);
      rs = run_start;
      first_done = -1;
      for (int i = 0; i < SEQ_LEN + 5; i++) begin
         c_next = cyc + 1 - rs;
         st = ($urandom_range(0, 7) == 0) && (c_next <= SEQ_LEN);
         if (first_done < 0 && done === 1'b1 && cyc > rs) first_done = cyc;
         step(st);
      end
      n_tests++;
      assert (first_done - rs === DONE_C) else begin
         n_fail++;
         $error("FAIL rerun_done_cycle observed=%0d expected=%0d", first_done - rs, DONE_C);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
